// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer and its decade counters.
package bcd_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned COUNT_W    = DIGIT_W * NUM_DIGITS;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  typedef struct packed {
    bcd_digit_t hundreds;
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_count_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  // Saturate an out-of-range nibble to the largest legal BCD digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic bcd_invalid(input bcd_digit_t d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD decade down-counter: load has priority over decrement, value held in 0-9.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  logic       borrow_i,
  output bcd_digit_t digit_o,
  output logic       borrow_o
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = bcd_clamp(load_val_i);
    end else if (borrow_i) begin
      // Wrap 0 -> 9; any illegal code also recovers to 9.
      digit_d = (digit_q == BCD_ZERO || digit_q > BCD_MAX) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o  = digit_q;
  assign borrow_o = borrow_i & (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Three-decade loadable BCD down-counter with IDLE/RUN/EXPIRED control and optional auto-reload.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               start,
  input  logic               stop,
  input  logic               enable,
  output logic [3:0]         ones,
  output logic [3:0]         tens,
  output logic [3:0]         hundreds,
  output logic               busy,
  output logic               done,
  output logic               load_err
);

  state_e     state_q, state_d;
  bcd_count_t reload_q, reload_d;
  logic       busy_q, done_q, done_d, load_err_q, load_err_d;

  bcd_count_t count_c;
  bcd_count_t load_clamp_c;
  bcd_count_t dig_val_c;
  logic       load_bad_c;
  logic       dig_load_c;
  logic       dec_en_c;
  logic       run_req_c;
  logic       count_zero_c;
  logic       count_one_c;
  logic       borrow0_c, borrow1_c;
  logic       unused_borrow_c;

  assign count_c      = {hundreds, tens, ones};
  assign count_zero_c = (count_c == COUNT_W'(12'h000));
  assign count_one_c  = (count_c == COUNT_W'(12'h001));
  assign run_req_c    = start & ~stop;

  always_comb begin
    load_clamp_c = '{hundreds: bcd_clamp(load_value[11:8]),
                     tens:     bcd_clamp(load_value[7:4]),
                     ones:     bcd_clamp(load_value[3:0])};
    load_bad_c   = bcd_invalid(load_value[11:8]) | bcd_invalid(load_value[7:4])
                 | bcd_invalid(load_value[3:0]);
  end

  // Command decode in priority order: clear > load > stop > start > enable.
  always_comb begin
    state_d    = state_q;
    reload_d   = reload_q;
    dig_load_c = 1'b0;
    dig_val_c  = '0;
    dec_en_c   = 1'b0;
    done_d     = 1'b0;
    load_err_d = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      reload_d   = '0;
      dig_load_c = 1'b1;
    end else if (load) begin
      reload_d   = load_clamp_c;
      dig_load_c = 1'b1;
      dig_val_c  = load_clamp_c;
      load_err_d = load_bad_c;
      state_d    = IDLE;
      if (run_req_c) begin
        if (load_clamp_c == '0) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (run_req_c) begin
            if (count_zero_c) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (enable) begin
            if (count_zero_c) begin
              state_d = EXPIRED;
            end else if (count_one_c) begin
              done_d = 1'b1;
              // A zero reload value would never expire again, so it falls back to one-shot.
              if (AUTO_RELOAD && (reload_q != '0)) begin
                dig_load_c = 1'b1;
                dig_val_c  = reload_q;
              end else begin
                state_d  = EXPIRED;
                dec_en_c = 1'b1;
              end
            end else begin
              dec_en_c = 1'b1;
            end
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      reload_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      reload_q   <= reload_d;
      busy_q     <= (state_d == RUN);
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  bcd_down_digit u_ones (
    .clk       (clk),
    .rst_n     (reset_n),
    .load_i    (dig_load_c),
    .load_val_i(dig_val_c.ones),
    .borrow_i  (dec_en_c),
    .digit_o   (ones),
    .borrow_o  (borrow0_c)
  );

  bcd_down_digit u_tens (
    .clk       (clk),
    .rst_n     (reset_n),
    .load_i    (dig_load_c),
    .load_val_i(dig_val_c.tens),
    .borrow_i  (borrow0_c),
    .digit_o   (tens),
    .borrow_o  (borrow1_c)
  );

  bcd_down_digit u_hundreds (
    .clk       (clk),
    .rst_n     (reset_n),
    .load_i    (dig_load_c),
    .load_val_i(dig_val_c.hundreds),
    .borrow_i  (borrow1_c),
    .digit_o   (hundreds),
    .borrow_o  (unused_borrow_c)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule
